// File: rtl/uart_packetizer.sv
// rtl/uart_packetizer.sv - frames FIFO bytes into SYNC0 SYNC1 SEQ LEN payload CHK packets for a UART
// Optional: define UART_PACKETIZER_CRC8_EN to make CHK a CRC-8 (poly 0x07) instead of an XOR checksum.
module uart_packetizer #(
    parameter int         MaxPayload    = 64,
    parameter logic [7:0] SyncByte0     = 8'hA5,
    parameter logic [7:0] SyncByte1     = 8'h5A,
    parameter int         TimeoutCycles = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] i_byte,
    input  logic       i_empty,
    output logic       o_fetch,
    input  logic       i_flush,
    input  logic       i_uart_ready,
    output logic [7:0] o_uart_byte,
    output logic       o_uart_valid,
    output logic       o_busy,
    output logic [7:0] o_seq
);

    localparam int IW = (MaxPayload > 1) ? $clog2(MaxPayload) : 1;
    localparam int TW = $clog2(TimeoutCycles + 1);
    localparam logic [7:0]    MAX_P      = 8'(MaxPayload);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TimeoutCycles - 1);

    localparam logic [2:0] S_COLLECT = 3'd0;
    localparam logic [2:0] S_HDR0    = 3'd1;
    localparam logic [2:0] S_HDR1    = 3'd2;
    localparam logic [2:0] S_SEQ     = 3'd3;
    localparam logic [2:0] S_LEN     = 3'd4;
    localparam logic [2:0] S_PAY     = 3'd5;
    localparam logic [2:0] S_CHK     = 3'd6;

    logic [2:0]    r_state;
    logic [7:0]    r_count;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_rd_idx;
    logic [7:0]    r_chk;
    logic          r_pending;
    logic [7:0]    r_seq;
    logic [7:0]    r_buf [0:MaxPayload-1];

    logic       w_collect;
    logic       w_fetch;
    logic       w_exit;
    logic       w_xfer;
    logic       w_pend_clr;
    logic [7:0] w_byte;

    // Running check value: CRC-8 bytewise in one step, or plain XOR.
    function automatic logic [7:0] f_chk_update(input logic [7:0] acc, input logic [7:0] data);
`ifdef UART_PACKETIZER_CRC8_EN
        logic [7:0] c;
        c = acc ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
`else
        return acc ^ data;
`endif
    endfunction

    assign w_collect = (r_state == S_COLLECT);
    // Fetch is held off while RST is high so no FIFO byte is consumed and lost during reset.
    assign w_fetch   = w_collect && !i_empty && (r_count < MAX_P) && !RST;
    // A fetch in the same cycle as a flush exit is still buffered and counted in LEN.
    assign w_exit    = w_collect && ((r_count == MAX_P) ||
                                     (r_pending && r_count != 8'd0) ||
                                     (!w_fetch && r_count != 8'd0 && r_timer == TIMER_LAST));
    assign w_xfer    = !w_collect && i_uart_ready;
    // A flush seen with nothing buffered (and nothing arriving) is dropped.
    assign w_pend_clr = w_exit || (w_collect && r_count == 8'd0 && !w_fetch);

    assign o_fetch      = w_fetch;
    assign o_uart_valid = !w_collect;
    assign o_busy       = !w_collect;
    assign o_uart_byte  = w_byte;
    assign o_seq        = r_seq;

    // Byte presented to the transmitter for the current packet field.
    always_comb begin
        w_byte = 8'h00;
        case (r_state)
            S_HDR0:  w_byte = SyncByte0;
            S_HDR1:  w_byte = SyncByte1;
            S_SEQ:   w_byte = r_seq;
            S_LEN:   w_byte = r_count;
            S_PAY:   w_byte = r_buf[r_rd_idx[IW-1:0]];
            S_CHK:   w_byte = r_chk;
            default: w_byte = 8'h00;
        endcase
    end

    // Payload storage; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge CLK) begin
        if (w_fetch) begin
            r_buf[r_count[IW-1:0]] <= i_byte;
        end
    end

    // Collection, idle timer, flush tracking and packet emission sequencing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_COLLECT;
            r_count   <= 8'd0;
            r_timer   <= '0;
            r_rd_idx  <= 8'd0;
            r_chk     <= 8'd0;
            r_pending <= 1'b0;
            r_seq     <= 8'd0;
        end else begin
            if (w_pend_clr) begin
                r_pending <= 1'b0;
            end else if (i_flush) begin
                r_pending <= 1'b1;
            end

            if (w_xfer && (r_state == S_SEQ || r_state == S_LEN || r_state == S_PAY)) begin
                r_chk <= f_chk_update(r_chk, w_byte);
            end

            case (r_state)
                S_COLLECT: begin
                    if (w_fetch) begin
                        r_count <= r_count + 8'd1;
                        r_timer <= '0;
                    end else if (r_count != 8'd0) begin
                        r_timer <= r_timer + TW'(1);
                    end
                    if (w_exit) begin
                        r_state <= S_HDR0;
                    end
                end
                S_HDR0: if (w_xfer) r_state <= S_HDR1;
                S_HDR1: if (w_xfer) r_state <= S_SEQ;
                S_SEQ:  if (w_xfer) r_state <= S_LEN;
                S_LEN:  if (w_xfer) r_state <= S_PAY;
                S_PAY: begin
                    if (w_xfer) begin
                        r_rd_idx <= r_rd_idx + 8'd1;
                        if (r_rd_idx == r_count - 8'd1) begin
                            r_state <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (w_xfer) begin
                        r_seq    <= r_seq + 8'd1;
                        r_count  <= 8'd0;
                        r_timer  <= '0;
                        r_rd_idx <= 8'd0;
                        r_chk    <= 8'd0;
                        r_state  <= S_COLLECT;
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

endmodule
